// File: rtl/riscv_defines.sv
// Shared type definitions for the RI5CY core slice used by the interrupt
// controller.
//   PrivLvl_t        : privilege level encoding (existing core type)
//   irq_ctrl_state_e : request handshake states of riscv_int_controller_mc
package riscv_defines;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } PrivLvl_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_DONE    = 2'd2
  } irq_ctrl_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Highest-index priority encoder (combinational).
//   req_i   : request vector, bit i = ID i
//   valid_o : any request set
//   id_o    : index of the highest set bit (0 when none)
module riscv_irq_prio_enc #(
  parameter int NUM_IRQ  = 32,
  parameter int IRQ_ID_W = 5
) (
  input  logic [NUM_IRQ-1:0]  req_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  // Ascending scan: the last hit, i.e. the highest index, wins.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req_i[i]) id_o = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/riscv_int_controller_mc.sv
// Multi-line interrupt controller between platform IRQ lines and the core
// controller. Picks the highest-index enabled pending line, presents it with
// the req/ack/kill handshake and returns an ack pulse with the serviced ID.
//   irq_i / irq_sec_i / irq_mask_i : lines, secure bits, per-line enables
//   m_IE_i / u_IE_i / current_priv_lvl_i : global enable inputs
//   irq_req_ctrl_o / irq_sec_ctrl_o / irq_id_ctrl_o : request to controller
//   ctrl_ack_i / ctrl_kill_i : controller response
//   irq_ack_o / irq_ack_id_o : serviced pulse to the platform
//   irq_pending_o : masked pending vector for CSR read-back
// Macro RISCV_INT_EDGE_EN: capture rising edges into a pending register
// (otherwise lines are level-sensitive).
module riscv_int_controller_mc
  import riscv_defines::*;
#(
  parameter int PULP_SECURE = 0,
  parameter int NUM_IRQ     = 32,
  parameter int IRQ_ID_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  irq_sec_i,
  input  logic [NUM_IRQ-1:0]  irq_mask_i,
  input  logic                m_IE_i,
  input  logic                u_IE_i,
  input  PrivLvl_t            current_priv_lvl_i,
  output logic                irq_req_ctrl_o,
  output logic                irq_sec_ctrl_o,
  output logic [IRQ_ID_W-1:0] irq_id_ctrl_o,
  input  logic                ctrl_ack_i,
  input  logic                ctrl_kill_i,
  output logic                irq_ack_o,
  output logic [IRQ_ID_W-1:0] irq_ack_id_o,
  output logic [NUM_IRQ-1:0]  irq_pending_o
);

  irq_ctrl_state_e     state_q, state_d;
  logic [IRQ_ID_W-1:0] id_q, id_d;
  logic                sec_q, sec_d;
  logic [NUM_IRQ-1:0]  pend, mpend;
  logic                sel_vld, sel_sec, en;
  logic [IRQ_ID_W-1:0] sel_id;

`ifdef RISCV_INT_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d;

  // Clear the serviced line first so a fresh edge in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    if (state_q == IRQ_DONE) pend_d[id_q] = 1'b0;
    pend_d = pend_d | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = irq_i;
`endif

  assign mpend         = pend & irq_mask_i;
  assign irq_pending_o = mpend;

  riscv_irq_prio_enc #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_ID_W (IRQ_ID_W)
  ) u_prio_enc (
    .req_i   (mpend),
    .valid_o (sel_vld),
    .id_o    (sel_id)
  );

  assign sel_sec = irq_sec_i[sel_id];

  // A secure line may interrupt user mode even with u_IE cleared.
  always_comb begin
    if (PULP_SECURE != 0)
      en = ((u_IE_i | sel_sec) & (current_priv_lvl_i == PRIV_LVL_U)) |
           (m_IE_i & (current_priv_lvl_i == PRIV_LVL_M));
    else
      en = m_IE_i;
  end

  // Arbitration only in IDLE: no preemption of a presented request.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    case (state_q)
      IDLE: begin
        if (en && sel_vld) begin
          id_d    = sel_id;
          sec_d   = sel_sec;
          state_d = IRQ_PENDING;
        end
      end
      IRQ_PENDING: begin
        if (ctrl_ack_i)       state_d = IRQ_DONE;
        else if (ctrl_kill_i) state_d = IDLE;
      end
      IRQ_DONE: begin
        sec_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      sec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sec_q   <= sec_d;
    end
  end

  assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
  assign irq_id_ctrl_o  = id_q;
  assign irq_sec_ctrl_o = sec_q;
  assign irq_ack_o      = (state_q == IRQ_DONE);
  // ID is driven only alongside the pulse; zero otherwise.
  assign irq_ack_id_o   = (state_q == IRQ_DONE) ? id_q : '0;

endmodule

// File: tb/tb_riscv_int_controller_mc.sv
// Bench for riscv_int_controller_mc: one instance with PULP_SECURE=0 and one
// with PULP_SECURE=1 share all inputs; a transaction-level model predicts
// both. Inputs change on the falling edge, outputs are compared there too.
module tb_riscv_int_controller_mc;
  import riscv_defines::*;

`ifdef RISCV_INT_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq, sec, mask;
  logic        m_ie, u_ie, ack, kill;
  PrivLvl_t    priv;

  logic [1:0]       req_o, sec_o, acko;
  logic [1:0][4:0]  id_o, ackid;
  logic [1:0][31:0] pendo;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  riscv_int_controller_mc #(.PULP_SECURE(0), .NUM_IRQ(32), .IRQ_ID_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(sec), .irq_mask_i(mask),
    .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
    .irq_req_ctrl_o(req_o[0]), .irq_sec_ctrl_o(sec_o[0]), .irq_id_ctrl_o(id_o[0]),
    .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_ack_o(acko[0]),
    .irq_ack_id_o(ackid[0]), .irq_pending_o(pendo[0]));

  riscv_int_controller_mc #(.PULP_SECURE(1), .NUM_IRQ(32), .IRQ_ID_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(sec), .irq_mask_i(mask),
    .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
    .irq_req_ctrl_o(req_o[1]), .irq_sec_ctrl_o(sec_o[1]), .irq_id_ctrl_o(id_o[1]),
    .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_ack_o(acko[1]),
    .irq_ack_id_o(ackid[1]), .irq_pending_o(pendo[1]));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        busy;  // request presented to controller
    logic        done;  // ack pulse cycle
    logic        sec;
    logic [4:0]  id;
    logic [31:0] pend;  // captured edges
    logic [31:0] prev;  // line values seen last cycle
  } m_t;

  m_t m [2];

  function automatic m_t nxt(m_t c, bit secure);
    m_t n;
    logic [31:0] mp, rise;
    int top;
    bit en, is_u, is_m;
    n    = c;
    mp   = (EDGE ? c.pend : irq) & mask;
    top  = -1;
    for (int i = 31; i >= 0; i--) if (mp[i] && top < 0) top = i;
    is_u = (priv == PRIV_LVL_U);
    is_m = (priv == PRIV_LVL_M);
    if (secure) en = ((u_ie | (top >= 0 && sec[top])) & is_u) | (m_ie & is_m);
    else        en = m_ie;
    rise   = irq & ~c.prev;
    n.prev = irq;
    n.pend = (c.done ? (c.pend & ~(32'h1 << c.id)) : c.pend) | rise;
    if (c.busy) begin
      if (ack) begin n.busy = 1'b0; n.done = 1'b1; end
      else if (kill) n.busy = 1'b0;
    end else if (c.done) begin
      n.done = 1'b0;
      n.sec  = 1'b0;
    end else if (top >= 0 && en) begin
      n.busy = 1'b1;
      n.id   = top[4:0];
      n.sec  = sec[top];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= nxt(m[0], 1'b0);
      m[1] <= nxt(m[1], 1'b1);
    end
  end

  // {req, sec, id, ack, ack_id, pending}
  function automatic logic [44:0] expv(int k);
    return {m[k].busy, m[k].sec, m[k].id, m[k].done,
            (m[k].done ? m[k].id : 5'd0), (EDGE ? m[k].pend : irq) & mask};
  endfunction

  function automatic logic [44:0] obsv(int k);
    return {req_o[k], sec_o[k], id_o[k], acko[k], ackid[k], pendo[k]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; irq = 32'h120; sec = '0; mask = '1;
    m_ie = 1'b1; u_ie = 1'b0; priv = PRIV_LVL_M; ack = 1'b0; kill = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsv(k) !== expv(k)) begin
        fails++; $display("FAIL reset dut%0d got=%h exp=%h", k, obsv(k), expv(k));
      end
    end
    checks++;
    if (req_o !== 2'b00 || acko !== 2'b00 || id_o[0] !== 5'd0) begin
      fails++; $display("FAIL reset_outputs got req=%b ack=%b id=%0d exp 0", req_o, acko, id_o[0]);
    end
    irq = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_level();
    irq = 32'h120; mask = '1;
    @(negedge clk);
    checks++;
    if (req_o[0] !== 1'b1 || id_o[0] !== 5'd8) begin
      fails++; $display("FAIL level_req got req=%b id=%0d exp req=1 id=8", req_o[0], id_o[0]);
    end
    @(negedge clk);
    ack = 1'b1; irq = '0;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (acko[0] !== 1'b1 || ackid[0] !== 5'd8) begin
      fails++; $display("FAIL level_ack got ack=%b id=%0d exp ack=1 id=8", acko[0], ackid[0]);
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          fails++; $display("FAIL level dut%0d got=%h exp=%h", k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_mask();
    irq = 32'h8000_0001; mask = 32'h7FFF_FFFF;
    @(negedge clk);
    checks++;
    if (req_o[0] !== 1'b1 || id_o[0] !== 5'd0 || pendo[0] !== 32'h1) begin
      fails++; $display("FAIL mask got req=%b id=%0d pend=%h exp req=1 id=0 pend=00000001",
                        req_o[0], id_o[0], pendo[0]);
    end
    ack = 1'b1; irq = '0;
    @(negedge clk);
    ack = 1'b0; mask = '1;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          fails++; $display("FAIL mask dut%0d got=%h exp=%h", k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_kill();
    irq = 32'h8;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (req_o[0] !== 1'b0 || acko[0] !== 1'b0) begin
      fails++; $display("FAIL kill_drop got req=%b ack=%b exp 0 0", req_o[0], acko[0]);
    end
    @(negedge clk);
    checks++;
    if (req_o[0] !== 1'b1 || id_o[0] !== 5'd3) begin
      fails++; $display("FAIL kill_rereq got req=%b id=%0d exp req=1 id=3", req_o[0], id_o[0]);
    end
    ack = 1'b1; kill = 1'b1; irq = '0;   // both at once: ack wins
    @(negedge clk);
    ack = 1'b0; kill = 1'b0;
    checks++;
    if (acko[0] !== 1'b1 || ackid[0] !== 5'd3) begin
      fails++; $display("FAIL ack_kill got ack=%b id=%0d exp ack=1 id=3", acko[0], ackid[0]);
    end
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          fails++; $display("FAIL kill dut%0d got=%h exp=%h", k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_secure();
    priv = PRIV_LVL_U; m_ie = 1'b0; u_ie = 1'b0;
    irq = 32'h20; sec = 32'h20;
    @(negedge clk);
    checks++;
    if (req_o !== 2'b10 || sec_o[1] !== 1'b1 || id_o[1] !== 5'd5) begin
      fails++; $display("FAIL secure_req got req=%b sec=%b id=%0d exp req=10 sec=1 id=5",
                        req_o, sec_o[1], id_o[1]);
    end
    ack = 1'b1; sec = '0;
    @(negedge clk);
    ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (req_o !== 2'b00) begin
        fails++; $display("FAIL nonsecure_user got req=%b exp 00", req_o);
      end
    end
    irq = '0; priv = PRIV_LVL_M; m_ie = 1'b1;
    @(negedge clk);
  endtask

`ifdef RISCV_INT_EDGE_EN
  task automatic test_edge();
    irq = 32'h4;
    @(negedge clk);
    irq = '0;
    @(negedge clk);
    checks++;
    if (req_o[0] !== 1'b1 || id_o[0] !== 5'd2) begin
      fails++; $display("FAIL edge_req got req=%b id=%0d exp req=1 id=2", req_o[0], id_o[0]);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    irq = 32'h4;                      // re-edge lands in the ack cycle
    @(negedge clk);
    irq = '0;
    @(negedge clk);
    checks++;
    if (req_o[0] !== 1'b1 || id_o[0] !== 5'd2) begin
      fails++; $display("FAIL edge_reedge got req=%b id=%0d exp req=1 id=2", req_o[0], id_o[0]);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          fails++; $display("FAIL random c%0d dut%0d got=%h exp=%h", c, k, obsv(k), expv(k));
        end
      end
      irq  = $urandom() & $urandom() & $urandom();
      sec  = $urandom();
      mask = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF;
      m_ie = ($urandom_range(0, 3) != 0);
      u_ie = $urandom_range(0, 1);
      priv = $urandom_range(0, 1) ? PRIV_LVL_M : PRIV_LVL_U;
      ack  = ($urandom_range(0, 2) == 0);
      kill = ($urandom_range(0, 3) == 0);
    end
    // asynchronous reset in the middle of traffic
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsv(k) !== expv(k)) begin
        fails++; $display("FAIL midreset dut%0d got=%h exp=%h", k, obsv(k), expv(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_level();
    test_mask();
    test_kill();
    test_secure();
`ifdef RISCV_INT_EDGE_EN
    test_edge();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/riscv_int_controller_mc.md
# riscv_int_controller_mc

Multi-line interrupt controller for the RI5CY core, sitting between the platform's interrupt lines and the core controller. It accepts NUM_IRQ interrupt lines with a per-line mask and per-line secure bit, and selects the highest-index enabled pending line. It presents that line to the controller with the existing req/ack/kill handshake and returns an acknowledge pulse with the serviced ID to the platform. Optionally it captures edge-triggered lines in a pending register.

## Interface
- PULP_SECURE, 0, 1: user-mode enable and secure-bit override active; 0: machine-mode enable only
- NUM_IRQ, 32, number of interrupt lines, legal range 1..32
- IRQ_ID_W, 5, width of interrupt ID, 2^IRQ_ID_W >= NUM_IRQ
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_i  in  NUM_IRQ  interrupt lines, bit i = ID i
- irq_sec_i  in  NUM_IRQ  secure bit per line
- irq_mask_i  in  NUM_IRQ  per-line enable from CSR, 1 = enabled
- m_IE_i  in  1  M-mode global interrupt enable
- u_IE_i  in  1  U-mode global interrupt enable
- current_priv_lvl_i  in  PrivLvl_t  current privilege level
- irq_req_ctrl_o  out  1  request to controller
- irq_sec_ctrl_o  out  1  secure bit of the latched request
- irq_id_ctrl_o  out  IRQ_ID_W  ID of the latched request
- ctrl_ack_i  in  1  controller has taken the interrupt
- ctrl_kill_i  in  1  controller drops the request
- irq_ack_o  out  1  one-cycle pulse, interrupt serviced
- irq_ack_id_o  out  IRQ_ID_W  ID of the serviced interrupt, valid with irq_ack_o
- irq_pending_o  out  NUM_IRQ  masked pending vector, for CSR read-back

## Operation
- pend = irq_i (level mode) or pend_q (edge mode). mpend = pend & irq_mask_i. irq_pending_o = mpend.
- Selection: the highest set index of mpend gives sel_id and sel_sec = irq_sec_i[sel_id].
- Enable, PULP_SECURE=1: en = ((u_IE_i | sel_sec) & priv==PRIV_LVL_U) | (m_IE_i & priv==PRIV_LVL_M). PULP_SECURE=0: en = m_IE_i.
- FSM states: IDLE, IRQ_PENDING, IRQ_DONE.
  - IDLE: if en & |mpend, latch id_q=sel_id and sec_q=sel_sec, then go to IRQ_PENDING.
  - IRQ_PENDING: ctrl_ack_i goes to IRQ_DONE. Otherwise ctrl_kill_i goes to IDLE. Otherwise stay. Ack has priority when ack and kill are both high.
  - IRQ_DONE: assert irq_ack_o with irq_ack_id_o=id_q, clear sec_q, go to IDLE.
- irq_req_ctrl_o = (state==IRQ_PENDING). irq_id_ctrl_o=id_q, irq_sec_ctrl_o=sec_q.
- No preemption: arbitration happens only in IDLE. A higher-priority line arriving during IRQ_PENDING waits.
- Kill leaves pend_q unchanged, so the line re-arbitrates from IDLE.
- Level mode: the line must be held by the source until it is serviced. Deassertion during IRQ_PENDING does not withdraw the request.

## Timing
- Reset values: irq_req_ctrl_o=0, irq_sec_ctrl_o=0, irq_id_ctrl_o=0, irq_ack_o=0, irq_ack_id_o=0, pend_q=0, irq_q=0, state IDLE. In level mode irq_pending_o equals irq_i & irq_mask_i during reset; otherwise 0.
- Level latency: line high in cycle N with state IDLE and en=1 gives irq_req_ctrl_o=1 in N+1.
- Edge latency: rising edge sampled in N sets pend_q in N+1, giving request in N+2.
- Ack in cycle K gives irq_ack_o=1 in K+1, state IDLE in K+2. The earliest next request is K+3.
- Reset mid-operation: immediate return to reset values, pending edges are lost.

## Configuration
- Macro RISCV_INT_EDGE_EN.
- Defined: irq_q samples irq_i each cycle. A rising edge (irq_i & ~irq_q) sets pend_q[i]. In IRQ_DONE, pend_q[id_q] clears. If a new edge on the same line arrives in the same cycle, the set wins.
- Undefined: level-triggered only. No irq_q or pend_q flops, and irq_ack_o is informational.

## Structure
- riscv_defines package: PrivLvl_t (existing), plus new irq_ctrl_state_e enum {IDLE, IRQ_PENDING, IRQ_DONE}.
- Sub-module riscv_irq_prio_enc: parametrised (NUM_IRQ, IRQ_ID_W) highest-index priority encoder. It outputs valid and id, and is combinational.
- Top level: FSM, enable logic, edge capture.

## Test plan
- Level, PULP_SECURE=0, m_IE=1, mask=all 1s, irq_i=0x0000_0120 -> irq_id_ctrl_o=8 one cycle later. After ack: irq_ack_o pulse with irq_ack_id_o=8.
- Mask: irq_i=0x8000_0001, mask=0x7FFF_FFFF -> ID 0 is selected, and irq_pending_o=0x0000_0001.
- Kill: while in IRQ_PENDING for ID 3, assert ctrl_kill_i -> IDLE with no irq_ack_o. The held line re-requests ID 3 two cycles later.
- Ack and kill in the same cycle -> IRQ_DONE and irq_ack_o=1.
- PULP_SECURE=1, priv=U, u_IE=0, line 5 with irq_sec_i[5]=1 -> request with irq_sec_ctrl_o=1. With irq_sec_i[5]=0 -> no request.
- RISCV_INT_EDGE_EN: pulse irq_i[2] for one cycle -> request ID 2 two cycles later. A re-edge on line 2 during IRQ_DONE leaves pend_q[2]=1, and ID 2 is requested again.
